// File: rtl/gray_binary_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshake for FIFO pointer paths.
// Gray->binary words are also checked for single-bit steps, with a saturating violation count.
module gray_binary_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_step_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) return c;
        return c + CNT_W'(1);
    endfunction

    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] data_p [STAGES];
    logic             mode_p [STAGES];
    logic             err_p  [STAGES];

    logic             adv;
    logic             accept;
    logic             gray_accept;
    logic [WIDTH-1:0] conv_data;
    logic             step_err;
    logic [WIDTH-1:0] prev_gray;
    logic             prev_vld;

    // Input side: conversion and step check are combinational, registered into slot 0
    assign out_valid   = vld_p[STAGES-1];
    assign adv         = out_ready | ~out_valid;
    assign in_ready    = adv;
    assign accept      = in_valid & adv;
    assign gray_accept = accept & ~in_mode;

    always_comb begin
        conv_data = in_mode ? bin2gray(in_data) : gray2bin(in_data);
        step_err  = ~in_mode & prev_vld & (popcount(in_data ^ prev_gray) > 32'd1);
    end

    // Slots shift together; bubbles travel with the stream rather than collapsing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                data_p[s] <= '0;
                mode_p[s] <= 1'b0;
                err_p[s]  <= 1'b0;
            end
        end else if (adv) begin
            for (int s = STAGES - 1; s > 0; s--) begin
                vld_p[s]  <= vld_p[s-1];
                data_p[s] <= data_p[s-1];
                mode_p[s] <= mode_p[s-1];
                err_p[s]  <= err_p[s-1];
            end
            vld_p[0]  <= accept;
            data_p[0] <= accept ? conv_data : '0;
            mode_p[0] <= accept & in_mode;
            err_p[0]  <= accept & step_err;
        end
    end

    // Step-check history only follows accepted Gray words, so idle X never reaches it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_gray <= '0;
            prev_vld  <= 1'b0;
        end else if (gray_accept) begin
            prev_gray <= in_data;
            prev_vld  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && step_err) begin
            err_count <= sat_inc(err_count);
        end
    end

    // Output side: last slot drives the ports directly
    assign out_data     = data_p[STAGES-1];
    assign out_mode     = mode_p[STAGES-1];
    assign out_step_err = err_p[STAGES-1];

endmodule
